// File: rtl/pipe_pkg.sv
// Shared definitions for the decode/execute pipeline stage register:
// state encoding, default payload widths and control-field bit positions.
package pipe_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      BUSY  = 2'd1,
      FULL  = 2'd2
   } pipe_state_t;

   localparam int PIPE_CTRL_W = 10;
   localparam int PIPE_DATA_W = 133;

   // Control field layout, MSB first: wreg, m2reg, wmem, aluc[3:0], aluimm, shift, jal
   localparam int CTRL_WREG     = 9;
   localparam int CTRL_M2REG    = 8;
   localparam int CTRL_WMEM     = 7;
   localparam int CTRL_ALUC_MSB = 6;
   localparam int CTRL_ALUC_LSB = 3;
   localparam int CTRL_ALUIMM   = 2;
   localparam int CTRL_SHIFT    = 1;
   localparam int CTRL_JAL      = 0;

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter; holds at all-ones instead of wrapping.
module pipe_sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   always_ff @(posedge clk) begin
      if (clr) begin
         count <= '0;
      end else if (inc && (count != {CNT_W{1'b1}})) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register with optional skid buffer and a
// saturating back-pressure counter.
//
//   state | meaning
//   EMPTY | no entry held, output is a bubble (NOP control)
//   BUSY  | one entry in main, presented downstream
//   FULL  | main presented, second entry parked in skid (SKID=1 only)
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int CTRL_W = PIPE_CTRL_W,
   parameter int DATA_W = PIPE_DATA_W,
   parameter int SKID   = 1,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              clr,
   input  logic              flush,
   input  logic              d_valid,
   output logic              d_ready,
   input  logic [CTRL_W-1:0] d_ctrl,
   input  logic [DATA_W-1:0] d_data,
   output logic              e_valid,
   input  logic              e_ready,
   output logic [CTRL_W-1:0] e_ctrl,
   output logic [DATA_W-1:0] e_data,
   output logic [CNT_W-1:0]  stall_cnt
);

   pipe_state_t       state, state_nxt;
   logic              ld_main_d, ld_main_skid, ld_skid;
   logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
   logic [DATA_W-1:0] main_data, skid_data;

   always_ff @(posedge clk) begin
      if (clr) begin
         state <= EMPTY;
      end else begin
         state <= state_nxt;
      end
   end

   // flush overrides the handshake: any same-cycle upstream entry is dropped
   always_comb begin
      state_nxt    = state;
      ld_main_d    = 1'b0;
      ld_main_skid = 1'b0;
      ld_skid      = 1'b0;
      if (flush) begin
         state_nxt = EMPTY;
      end else begin
         case (state)
            EMPTY: begin
               if (d_valid) begin
                  ld_main_d = 1'b1;
                  state_nxt = BUSY;
               end
            end
            BUSY: begin
               if (e_ready) begin
                  if (d_valid) begin
                     ld_main_d = 1'b1;
                  end else begin
                     state_nxt = EMPTY;
                  end
               end else if (d_valid && (SKID != 0)) begin
                  ld_skid   = 1'b1;
                  state_nxt = FULL;
               end
            end
            FULL: begin
               if (e_ready) begin
                  ld_main_skid = 1'b1;
                  state_nxt    = BUSY;
               end
            end
            default: state_nxt = EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         main_ctrl <= '0;
         main_data <= '0;
      end else if (ld_main_d) begin
         main_ctrl <= d_ctrl;
         main_data <= d_data;
      end else if (ld_main_skid) begin
         main_ctrl <= skid_ctrl;
         main_data <= skid_data;
      end
   end

   generate
      if (SKID != 0) begin : g_skid
         always_ff @(posedge clk) begin
            if (clr) begin
               skid_ctrl <= '0;
               skid_data <= '0;
            end else if (ld_skid) begin
               skid_ctrl <= d_ctrl;
               skid_data <= d_data;
            end
         end
         // decoded from the state register only, so e_ready never reaches d_ready
         assign d_ready = (state != FULL);
      end else begin : g_noskid
         assign skid_ctrl = '0;
         assign skid_data = '0;
         assign d_ready   = e_ready | ~e_valid;
      end
   endgenerate

   assign e_valid = (state != EMPTY);
   assign e_ctrl  = e_valid ? main_ctrl : '0;
   assign e_data  = main_data;

   pipe_sat_counter #(
      .CNT_W (CNT_W)
   ) u_stall_cnt (
      .clk   (clk),
      .clr   (clr),
      .inc   (e_valid & ~e_ready),
      .count (stall_cnt)
   );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: default skid build, a 4-bit counter
// build for saturation, and a SKID=0 build, all driven from one stimulus.
module tb_pipe_stage_reg;

   localparam int CW = 10;
   localparam int DW = 133;

   logic          clk, clr, flush, d_valid, e_ready;
   logic [CW-1:0] d_ctrl;
   logic [DW-1:0] d_data;

   logic          d_ready, e_valid;
   logic [CW-1:0] e_ctrl;
   logic [DW-1:0] e_data;
   logic [15:0]   stall_cnt;

   logic          s_d_ready, s_e_valid;
   logic [CW-1:0] s_e_ctrl;
   logic [DW-1:0] s_e_data;
   logic [3:0]    s_stall_cnt;

   logic          n_d_ready, n_e_valid;
   logic [CW-1:0] n_e_ctrl;
   logic [DW-1:0] n_e_data;
   logic [15:0]   n_stall_cnt;

   int checks = 0;
   int errors = 0;

   pipe_stage_reg dut (
      .clk(clk), .clr(clr), .flush(flush), .d_valid(d_valid), .d_ready(d_ready),
      .d_ctrl(d_ctrl), .d_data(d_data), .e_valid(e_valid), .e_ready(e_ready),
      .e_ctrl(e_ctrl), .e_data(e_data), .stall_cnt(stall_cnt)
   );

   pipe_stage_reg #(.CNT_W(4)) dut_sat (
      .clk(clk), .clr(clr), .flush(flush), .d_valid(d_valid), .d_ready(s_d_ready),
      .d_ctrl(d_ctrl), .d_data(d_data), .e_valid(s_e_valid), .e_ready(e_ready),
      .e_ctrl(s_e_ctrl), .e_data(s_e_data), .stall_cnt(s_stall_cnt)
   );

   pipe_stage_reg #(.SKID(0)) dut_ns (
      .clk(clk), .clr(clr), .flush(flush), .d_valid(d_valid), .d_ready(n_d_ready),
      .d_ctrl(d_ctrl), .d_data(d_data), .e_valid(n_e_valid), .e_ready(e_ready),
      .e_ctrl(n_e_ctrl), .e_data(n_e_data), .stall_cnt(n_stall_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic offer(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d);
      d_valid = v;
      d_ctrl  = c;
      d_data  = d;
   endtask

   initial begin
      clr = 1'b1; flush = 1'b0; e_ready = 1'b0;
      offer(1'b0, '0, '0);
      tick(); tick();
      chk("rst_e_valid", e_valid, 0);
      chk("rst_e_ctrl", e_ctrl, 0);
      chk("rst_stall", stall_cnt, 0);
      chk("rst_d_ready", d_ready, 1);
      chk("rst_sat_stall", s_stall_cnt, 0);

      // streaming, payloads 1..8
      clr = 1'b0; e_ready = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         offer(1'b1, 10'h200 | 10'(i), DW'(i));
         tick();
         chk("str_e_valid", e_valid, 1);
         chk("str_e_data", e_data, DW'(i));
         chk("str_e_ctrl", e_ctrl, 10'h200 | 10'(i));
         chk("str_d_ready", d_ready, 1);
      end
      offer(1'b0, '0, '0);
      tick();
      chk("str_bubble_valid", e_valid, 0);
      chk("str_bubble_ctrl", e_ctrl, 0);
      chk("str_stall", stall_cnt, 0);

      // back-pressure: A loaded, B to skid, C held upstream
      e_ready = 1'b0;
      offer(1'b1, 10'h0AA, DW'('hA));
      tick();
      chk("bp_a_valid", e_valid, 1);
      offer(1'b1, 10'h0BB, DW'('hB));
      chk("bp_b_ready", d_ready, 1);
      tick();
      chk("bp_full_ready", d_ready, 0);
      chk("bp_hold_a", e_data, DW'('hA));
      offer(1'b1, 10'h0CC, DW'('hC));
      tick(); tick();
      chk("bp_stall3", stall_cnt, 3);
      chk("bp_still_a", e_data, DW'('hA));
      e_ready = 1'b1;
      tick();
      chk("bp_out_b", e_data, DW'('hB));
      chk("bp_out_b_ctrl", e_ctrl, 10'h0BB);
      chk("bp_ready_again", d_ready, 1);
      tick();
      chk("bp_out_c", e_data, DW'('hC));
      offer(1'b0, '0, '0);
      tick();
      chk("bp_drained", e_valid, 0);
      chk("bp_stall_keep", stall_cnt, 3);

      // flush while FULL with D offered
      e_ready = 1'b0;
      offer(1'b1, 10'h3FF, DW'('h1A));
      tick();
      offer(1'b1, 10'h3FE, DW'('h1B));
      tick();
      chk("fl_full", d_ready, 0);
      chk("fl_stall4", stall_cnt, 4);
      flush = 1'b1;
      offer(1'b1, 10'h3FD, DW'('h1D));
      tick();
      flush = 1'b0;
      chk("fl_e_valid", e_valid, 0);
      chk("fl_e_ctrl", e_ctrl, 0);
      chk("fl_d_ready", d_ready, 1);
      chk("fl_stall_kept", stall_cnt, 5);
      offer(1'b0, '0, '0);
      tick();
      chk("fl_d_dropped", e_valid, 0);

      // reset while FULL
      offer(1'b1, 10'h111, DW'('h2A));
      tick();
      offer(1'b1, 10'h122, DW'('h2B));
      tick();
      chk("rf_full", d_ready, 0);
      clr = 1'b1;
      offer(1'b0, '0, '0);
      tick();
      chk("rf_e_valid", e_valid, 0);
      chk("rf_stall", stall_cnt, 0);
      chk("rf_e_ctrl", e_ctrl, 0);
      chk("rf_e_data", e_data, 0);
      clr = 1'b0; e_ready = 1'b1;
      offer(1'b1, 10'h133, DW'('h2E));
      tick();
      chk("rf_first_e", e_data, DW'('h2E));
      offer(1'b0, '0, '0);
      tick();
      chk("rf_no_stale", e_valid, 0);

      // saturation of the 4-bit counter
      e_ready = 1'b0;
      offer(1'b1, 10'h001, DW'('h55));
      tick();
      offer(1'b0, '0, '0);
      for (int i = 0; i < 20; i++) tick();
      chk("sat_cnt4", s_stall_cnt, 15);
      chk("sat_cnt16", stall_cnt, 20);

      // SKID=0 build: combinational d_ready and streaming
      clr = 1'b1;
      tick();
      clr = 1'b0;
      offer(1'b1, 10'h0A0, DW'('hA0));
      chk("ns_empty_ready", n_d_ready, 1);
      tick();
      offer(1'b0, '0, '0);
      chk("ns_hold_ready", n_d_ready, 0);
      e_ready = 1'b1;
      #1;
      chk("ns_ready_rise", n_d_ready, 1);
      e_ready = 1'b0;
      #1;
      chk("ns_ready_fall", n_d_ready, 0);
      e_ready = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         offer(1'b1, 10'h040 | 10'(i), DW'('h100 + i));
         tick();
         chk("ns_str_valid", n_e_valid, 1);
         chk("ns_str_data", n_e_data, DW'('h100 + i));
      end
      offer(1'b0, '0, '0);
      tick();
      chk("ns_drained", n_e_valid, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
